shift_pipe_stage: RTL and testbench
===================================

// Module: shift_pipe_stage
// PURPOSE
//  Registered two-stage front end for the ALU32 shifter path. Accepts operand pair + shift op over
//  valid/ready, registers operands (stage 1), performs SLL/SRL/SRA on stage-1 regs, and registers the
//  result plus flags (stage 2) for the ALU result mux / writeback. Full throughput, backpressure-safe.
// PARAMETERS
//  WIDTH    32  datapath width; shift amount = low $clog2(WIDTH) bits of in_b (5 bits at 32)
//  COUNT_W  16  width of completed-operation counter ops_done (wraps)
// PORTS
//  clk        in   1        single clock, all state on posedge
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        synchronous: drop all in-flight ops this cycle
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        stage 1 can accept
//  in_a       in   WIDTH    value to shift
//  in_b       in   WIDTH    shift amount source; only low SHAMT bits used
//  in_op      in   2        00 SLL, 01 SRL, 11 SRA, 10 reserved
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_result out  WIDTH    shifted value
//  out_zero   out  1        out_result == 0
//  out_err    out  1        op was reserved (10)
//  ops_done   out  COUNT_W  count of results handed off (out_valid & out_ready)
// BEHAVIOUR
//  Reset (async, any time): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_zero=0,
//   out_err=0, ops_done=0. In-flight ops discarded; no partial output after release.
//  Amount: shamt = in_b[$clog2(WIDTH)-1:0]; upper bits ignored (36 -> 4). shamt=0 -> passthrough.
//  SLL: a << shamt, zero fill. SRL: a >> shamt, zero fill. SRA: sign fill from a[WIDTH-1].
//  Reserved op 10: out_result = a unchanged, out_err=1; still counted in ops_done.
//  Handshake: transfer when valid & ready same edge. in_valid/out_valid never depend combinationally
//   on ready. Payload of out_* stable while out_valid & !out_ready.
//  Advance: s2_adv = !s2_valid | out_ready; in_ready = !s1_valid | s2_adv (combinational from out_ready).
//  Stage 1: on in_valid & in_ready load {a, shamt, op}, s1_valid=1; else if s2_adv s1_valid=0.
//  Stage 2: if s2_adv, s2 <= shift(s1), s2_valid <= s1_valid; else hold.
//  Latency: accept at edge N -> out_valid high after edge N+2 with out_ready held high.
//  Throughput: 1 op/cycle when out_ready high. Under stall holds exactly 2 ops (s1+s2), in_ready=0.
//  Flush: next edge s1_valid=0, s2_valid=0; concurrent in beat NOT accepted (in_ready forced 0
//   while flush=1); concurrent out handshake completes and is counted. Flags/data regs may keep
//   stale values but out_valid=0.
//  ops_done: +1 per out handshake, wraps 2^COUNT_W-1 -> 0. Not cleared by flush.
//  out_zero/out_err registered with out_result, same cycle.
// TESTING
//  1 SLL a=0x00000001 b=0x00000024 (shamt 4) -> out_result=0x00000010, zero=0, err=0, 2-cycle latency
//  2 SRA a=0x80000000 b=31 -> 0xFFFFFFFF; SRL same operands -> 0x00000001; SLL a=0x1 b=32 -> 0x1
//  3 back-to-back 8 ops, out_ready=1 -> 8 results in order, 1/cycle, ops_done=8; then out_ready=0 with
//    in_valid=1 -> in_ready drops after 2 accepted, payload stable until release, none lost/duplicated
//  4 op=10 a=0xDEADBEEF -> out_result=0xDEADBEEF, err=1; SLL a=0x80000000 b=1 -> 0, zero=1
//  5 flush with in_valid=1 and both stages full, out_ready=1 -> one result counted, next cycle
//    out_valid=0, new beat not taken; rst pulsed mid-stream -> all outputs 0 immediately, ops_done=0
//  6 force ops_done=0xFFFE via 2^16-2 ops (or COUNT_W=4 variant) -> two more handshakes wrap to 0x0000

Source files
------------

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage
//   Two-stage registered shifter front end for the ALU32 shifter path.
//   Stage 1 registers the operand beat {a, shamt, op}; stage 2 registers the
//   shifted result together with its zero/error flags. Valid/ready on both
//   sides, one operation per cycle when the consumer is ready, and exactly two
//   operations held when it stalls.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous drop of every in-flight operation
//   in_valid   : operand beat valid
//   in_ready   : stage 1 can accept a beat (forced low while flush is high)
//   in_a       : value to shift
//   in_b       : shift amount source, only the low $clog2(WIDTH) bits are used
//   in_op      : 00 SLL, 01 SRL, 11 SRA, 10 reserved (passthrough + error)
//   out_valid  : result valid
//   out_ready  : consumer accepts the result
//   out_result : shifted value
//   out_zero   : out_result == 0
//   out_err    : operation used the reserved encoding
//   ops_done   : wrapping count of completed output handshakes
module shift_pipe_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_err,
    output logic [COUNT_W-1:0] ops_done
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    // Stage 1 registers
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [SHAMT_W-1:0] r_s1_shamt;
    shift_op_e          r_s1_op;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_result;
    logic               r_s2_zero;
    logic               r_s2_err;
    logic [COUNT_W-1:0] r_ops_done;

    // Combinational
    logic               w_s2_adv;
    logic               w_accept;
    logic               w_out_hs;
    logic [WIDTH-1:0]   w_shift_res;
    logic               w_shift_err;

    // Stage 2 can take a new value when it is empty or being drained this edge.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !flush && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_s2_valid && out_ready;

    always_comb begin
        w_shift_res = r_s1_a;
        w_shift_err = 1'b0;
        case (r_s1_op)
            OP_SLL:  w_shift_res = r_s1_a << r_s1_shamt;
            OP_SRL:  w_shift_res = r_s1_a >> r_s1_shamt;
            OP_SRA:  w_shift_res = $unsigned($signed(r_s1_a) >>> r_s1_shamt);
            default: begin
                w_shift_res = r_s1_a;
                w_shift_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_shamt <= '0;
            r_s1_op    <= OP_SLL;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= in_a;
            r_s1_shamt <= in_b[SHAMT_W-1:0];
            r_s1_op    <= shift_op_e'(in_op);
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Flush only clears the valid bit; data and flags may load stale values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_err    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid  <= r_s1_valid && !flush;
            r_s2_result <= w_shift_res;
            r_s2_zero   <= (w_shift_res == '0);
            r_s2_err    <= w_shift_err;
        end else if (flush) begin
            r_s2_valid  <= 1'b0;
        end
    end

    // A handshake coinciding with flush still completes and is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ops_done <= '0;
        end else if (w_out_hs) begin
            r_ops_done <= r_ops_done + COUNT_W'(1);
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_zero   = r_s2_zero;
    assign out_err    = r_s2_err;
    assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_shift_pipe_stage.sv
module tb_shift_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready4;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_valid4;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_result4;
    logic        out_zero;
    logic        out_zero4;
    logic        out_err;
    logic        out_err4;
    logic [15:0] ops_done;
    logic [3:0]  ops_done4;

    always #5 clk = ~clk;

    shift_pipe_stage #(.WIDTH(32), .COUNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
        .ops_done(ops_done)
    );

    // Narrow-counter instance on the same stimulus, used for the wrap check.
    shift_pipe_stage #(.WIDTH(32), .COUNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_result(out_result4), .out_zero(out_zero4), .out_err(out_err4),
        .ops_done(ops_done4)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [15:0] model_cnt = '0;
    logic        stall_pend = 1'b0;
    logic [31:0] stall_res = '0;
    logic        hs_last = 1'b0;
    logic        acc_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference shifter from arithmetic: scaling by powers of two.
    function automatic exp_t ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int unsigned sh;
        longint unsigned p;
        longint unsigned wide;
        sh   = b % 32;
        p    = 64'd1 << sh;
        wide = {32'd0, a};
        e.err = 1'b0;
        case (op)
            2'b00: e.res = 32'((wide * p) % (64'd1 << 32));
            2'b01: e.res = 32'(wide / p);
            2'b11: begin
                if (a[31]) e.res = ~32'({32'd0, ~a} / p);
                else       e.res = 32'(wide / p);
            end
            default: begin
                e.res = a;
                e.err = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // One clock cycle: drive at negedge, check against the occupancy model, advance.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic fl);
        exp_t e;
        logic exp_rdy;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && (q.size() < 2 || ordy);
        chk("in_ready", in_ready, exp_rdy);
        chk("ops_done", ops_done, model_cnt);
        chk("ops_done_w4", ops_done4, model_cnt[3:0]);
        if (stall_pend) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, stall_res);
        end
        hs_last  = 1'b0;
        acc_last = 1'b0;
        if (q.size() == 0) begin
            chk("spurious_valid", out_valid, 0);
        end else if (out_valid) begin
            e = q[0];
            chk("result", out_result, e.res);
            chk("zero", out_zero, e.zero);
            chk("err", out_err, e.err);
            if (ordy) begin
                void'(q.pop_front());
                model_cnt++;
                hs_last = 1'b1;
            end
        end
        if (v && exp_rdy) begin
            q.push_back(ref_op(op, a, b));
            acc_last = 1'b1;
        end
        if (fl) q.delete();
        stall_pend = out_valid && !ordy && !fl;
        stall_res  = out_result;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 2'b00, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    // Asserts reset asynchronously mid-cycle and checks outputs clear at once.
    task automatic pulse_reset;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_ops_done_w4", ops_done4, 0);
        q.delete();
        model_cnt  = '0;
        stall_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        int acc_cnt;
        int hs_cnt;
        int bound;

        vecs[0]  = '{2'b00, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 32'h00000001, 32'd32,       32'h00000001, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[5]  = '{2'b00, 32'h80000000, 32'd1,        32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 32'hF0000000, 32'hFFFFFFE4, 32'h0F000000, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 32'h00000000, 32'd5,        32'h00000000, 1'b1, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_op = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_ops_done", ops_done, 0);
        rst = 1'b0;

        // Directed vectors, one at a time, with two-edge latency checks.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
            chk("lat_edge1_valid", out_valid, 0);
            idle(1'b1);
            chk("lat_edge2_valid", out_valid, 1);
            chk("vec_result", out_result, vecs[i].res);
            chk("vec_zero", out_zero, vecs[i].zero);
            chk("vec_err", out_err, vecs[i].err);
            idle(1'b1);
            chk("vec_drained", out_valid, 0);
        end

        // Back-to-back 8 ops from a fresh counter.
        pulse_reset();
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, 1'b0);
            else       idle(1'b1);
            if (i >= 2) chk("throughput_hs", hs_last, 1);
            if (hs_last) hs_cnt++;
        end
        chk("b2b_hs_count", hs_cnt, 8);
        chk("b2b_ops_done", ops_done, 16'd8);
        chk("b2b_empty", q.size(), 0);

        // Stall: only two beats enter, payload holds, nothing lost on release.
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, 1'b0);
            if (acc_last) acc_cnt++;
        end
        chk("stall_accepted", acc_cnt, 2);
        hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (hs_last) hs_cnt++;
        end
        chk("stall_released", hs_cnt, 2);
        chk("stall_ops_done", ops_done, 16'd10);

        // Flush with both stages full and a concurrent out handshake.
        cycle(1'b1, 2'b00, 32'h1, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 32'h2, 32'h1, 1'b0, 1'b0);
        chk("flush_pre_valid", out_valid, 1);
        cycle(1'b1, 2'b00, 32'h3, 32'h1, 1'b1, 1'b1);
        chk("flush_hs_counted", hs_last, 1);
        chk("flush_not_accepted", acc_last, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_ops_done", ops_done, 16'd11);
        idle(1'b1);
        idle(1'b1);
        chk("flush_stays_empty", out_valid, 0);

        // Reset in the middle of a stream.
        cycle(1'b1, 2'b01, $urandom, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 2'b11, $urandom, $urandom, 1'b0, 1'b0);
        pulse_reset();
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_valid", out_valid, 0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end
        bound = 0;
        while (q.size() != 0 && bound < 10) begin
            idle(1'b1);
            bound++;
        end
        chk("random_drained", q.size(), 0);

        // Wrap of the 4-bit counter: reach 14, then two handshakes give 0.
        bound = 0;
        while (model_cnt[3:0] != 4'd14 && bound < 40) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, 1'b0);
            bound++;
        end
        chk("wrap_pre", ops_done4, 4'hE);
        chk("wrap_inflight", q.size(), 2);
        idle(1'b1);
        idle(1'b1);
        chk("wrap_zero", ops_done4, 4'h0);
        chk("wrap_wide", ops_done, model_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
